// File: rtl/wb_dual_master_arbiter_if.sv
// Classic Wishbone bus bundle shared by the two upstream masters and the memory port.
// Error signalling is carried as sideband ports on the arbiter, not on this bus.
interface wb_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [DATA_WIDTH/8-1:0]   sel;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_WIDTH-1:0]     dat_w;
  logic [DATA_WIDTH-1:0]     dat_r;
  logic                      ack;

  modport master (output cyc, stb, we, sel, addr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, addr, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin arbiter merging instruction (m0) and data (m1) Wishbone masters onto one slave.
// Optional BUSY watchdog returning mX_err is enabled with the WB_ARB_TIMEOUT_EN macro.
//
// state | meaning
// IDLE  | slave port quiet; pick a winner from pending requests
// BUSY  | granted master muxed straight through to the slave until ack/abort/timeout
module wb_dual_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic      clk_core,
  input  logic      rst_core,
  wb_arb_if.slave   m0,
  wb_arb_if.slave   m1,
  wb_arb_if.master  s,
  output logic      m0_err,
  output logic      m1_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  logic   grant;
  logic   last_grant;

  logic req0, req1, busy, winner, timeout_hit;
  logic g_cyc, g_stb, g_we;
  logic [DATA_WIDTH/8-1:0] g_sel;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic [DATA_WIDTH-1:0]   g_dat_w;
  logic ack0, ack1;

  assign req0   = m0.cyc & m0.stb;
  assign req1   = m1.cyc & m1.stb;
  assign busy   = (state == BUSY);
  // On a tie the master that did not win last time goes first.
  assign winner = (req0 & req1) ? ~last_grant : req1;

  assign g_cyc   = grant ? m1.cyc   : m0.cyc;
  assign g_stb   = grant ? m1.stb   : m0.stb;
  assign g_we    = grant ? m1.we    : m0.we;
  assign g_sel   = grant ? m1.sel   : m0.sel;
  assign g_addr  = grant ? m1.addr  : m0.addr;
  assign g_dat_w = grant ? m1.dat_w : m0.dat_w;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] tmo_cnt;
  assign timeout_hit = busy & g_cyc & ~s.ack & (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      if (!busy)
        tmo_cnt <= '0;
      else if (!s.ack)
        tmo_cnt <= tmo_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (s.ack) begin
            last_grant <= grant;
            state      <= IDLE;
          end else if (!g_cyc) begin
            // Abort: master gave up, fairness history is left untouched.
            state <= IDLE;
          end else if (timeout_hit) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s.cyc   = busy & g_cyc;
  assign s.stb   = busy & g_cyc & g_stb;
  assign s.we    = busy & g_cyc & g_we;
  assign s.sel   = busy ? g_sel   : '0;
  assign s.addr  = busy ? g_addr  : '0;
  assign s.dat_w = busy ? g_dat_w : '0;

  assign ack0     = busy & ~grant & s.ack;
  assign ack1     = busy &  grant & s.ack;
  assign m0.ack   = ack0;
  assign m1.ack   = ack1;
  assign m0.dat_r = ack0 ? s.dat_r : '0;
  assign m1.dat_r = ack1 ? s.dat_r : '0;

  assign m0_err = timeout_hit & ~grant;
  assign m1_err = timeout_hit &  grant;

endmodule

// File: doc/wb_dual_master_arbiter.md
Name: wb_dual_master_arbiter

Overview:
- Merges the instruction-side and data-side Wishbone masters, i.e. the outputs of the two AHB-to-Wishbone bridges, onto one classic (non-pipelined) Wishbone slave port.
- Sits directly downstream of the bridges and upstream of the Controller memory port.
- Used in builds without ENABLE_SECOND_MEMORY, where a single memory serves both buses.
- Arbitration is round-robin, one outstanding transaction at a time.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports; the sel width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, number of BUSY cycles without ack before an error is returned. Used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk_core  in  1  core clock; all logic on its rising edge.
- rst_core  in  1  synchronous, active-high reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 (instruction) control.
- m0_sel  in  DATA_WIDTH/8  master 0 byte selects.
- m0_addr  in  ADDR_WIDTH  master 0 address.
- m0_dat_w  in  DATA_WIDTH  master 0 write data.
- m0_dat_r  out  DATA_WIDTH  master 0 read data.
- m0_ack  out  1  master 0 acknowledge.
- m0_err  out  1  master 0 error (timeout).
- m1_*  same set as m0_*  master 1 (data).
- s_cyc, s_stb, s_we  out  1 each  slave control.
- s_sel  out  DATA_WIDTH/8  slave byte selects.
- s_addr  out  ADDR_WIDTH  slave address.
- s_dat_w  out  DATA_WIDTH  slave write data.
- s_dat_r  in  DATA_WIDTH  slave read data.
- s_ack  in  1  slave acknowledge.

Behaviour:
- Reset: state=IDLE, last_grant=1 so m0 wins the first tie, timeout counter=0.
  - s_cyc/s_stb/s_we=0, s_sel=0, s_addr=0, s_dat_w=0.
  - m0_ack/m1_ack/m0_err/m1_err=0.
- Request: mX_req = mX_cyc & mX_stb.
- State IDLE:
  - Slave outputs forced to zero.
  - If any request is present, choose the winner, register grant, go to BUSY.
  - Tie: the master != last_grant wins.
  - No request: stay in IDLE.
- State BUSY:
  - s_cyc/s_stb/s_we/s_sel/s_addr/s_dat_w are a combinational mux of the granted master's inputs.
  - Request seen in cycle N, so s_stb is high in cycle N+1.
- Ack routing:
  - m{grant}_ack = s_ack, combinational, same cycle.
  - Non-granted ack is always 0; acks are never issued in IDLE.
  - s_dat_r is broadcast to both mX_dat_r and is qualified by ack.
- Completion: on s_ack in BUSY, last_grant<=grant and next state is IDLE.
  - This guarantees one dead cycle between transactions.
  - The next transaction's s_stb appears 2 cycles after the previous ack.
- Abort: granted master drops cyc while BUSY with no s_ack.
  - s_cyc/s_stb follow low the same cycle.
  - Next state IDLE; last_grant is unchanged.
  - No ack or err is issued.
- Stale ack: s_ack while IDLE is ignored and not forwarded.
- Reset mid-transaction: all state returns to reset values next edge; slave outputs drop to 0.
- Throughput: worst-case latency for a waiting master is one full transaction of the other master plus 1 cycle.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter clears on entry to BUSY and increments each BUSY cycle without s_ack.
  - In the cycle where count == TIMEOUT_CYCLES-1 and s_ack=0, m{grant}_err pulses for 1 cycle with ack=0.
  - Next state is IDLE, so s_cyc drops next cycle; last_grant<=grant.
  - s_ack arriving in that same cycle wins: normal ack, no err.
- Undefined:
  - No counter; m0_err=m1_err=0 constant.
  - BUSY waits indefinitely for s_ack or an abort.

Test Plan:
- Single read:
  - Stimulus: m0 req addr 0x0000_0100 at cycle 0; slave acks in cycle 3 with 0xCAFEBABE.
  - Required: s_stb=1, s_addr=0x100 in cycle 1; m0_ack=1, m0_dat_r=0xCAFEBABE in cycle 3; m1_ack=0 throughout.
- Simultaneous requests after reset:
  - Stimulus: m0 addr 0x10, m1 addr 0x2000 at cycle 0.
  - Required: m0 granted in cycle 1; with slave ack at cycle k, s_addr=0x2000 with s_stb=1 in cycle k+2.
- Fairness:
  - Stimulus: both masters request continuously; slave acks 1 cycle after s_stb; run 4 transactions.
  - Required: grant order 0,1,0,1; each m*_ack pulse is 1 cycle wide.
- Write:
  - Stimulus: m1 we=1, sel=0011, dat_w=0x12345678, addr 0x8000_0004.
  - Required: s_we=1, s_sel=0011, s_dat_w=0x12345678, s_addr=0x8000_0004; m1_ack on s_ack.
- Abort:
  - Stimulus: m0 granted; m0_cyc=0 in cycle 2 with no ack while m1 is pending.
  - Required: s_cyc=0 in cycle 2; m1 on slave with s_stb=1 in cycle 4; no m0_ack and no m0_err.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: m0 read, slave never acks.
  - Required: m0_err=1 in the 8th BUSY cycle for exactly 1 cycle, m0_ack=0, s_cyc=0 next cycle.
  - Rerun with s_ack in that cycle: m0_ack=1, m0_err=0.
